// File: rtl/cr16_pkg.sv
// cr16_pkg: shared encodings for the CR16 control unit and datapath.
package cr16_pkg;
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;

    localparam logic [3:0] EXT_ADD   = 4'b0101;
    localparam logic [3:0] EXT_SUB   = 4'b1001;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_LSH   = 4'b0100;

    localparam logic [3:0] COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4,  COND_LS = 4'd5,  COND_GT = 4'd6,  COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8,  COND_FC = 4'd9,  COND_LO = 4'd10, COND_HS = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12, COND_GE = 4'd13, COND_UC = 4'd14, COND_NV = 4'd15;

    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    localparam logic [1:0] CR_SHIFT = 2'b00;
    localparam logic [1:0] CR_ALU   = 2'b01;
    localparam logic [1:0] CR_IMM   = 2'b10;
    localparam logic [1:0] CR_LINK  = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_ALU, S_SHIFT, S_LOAD_ADDR, S_LOAD_WB,
        S_STORE, S_BRANCH, S_JUMP, S_JAL, S_PCINC
    } state_t;

    // R-type ext codes and immediate opcodes share the same ALU code set
    function automatic logic is_alu_code(input logic [3:0] c);
        return c inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b1011, 4'b1101};
    endfunction
endpackage

// File: rtl/cond_eval.sv
// cond_eval: evaluates a branch/jump condition code against the PSR flags.
module cond_eval
    import cr16_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [7:0] psr,
    output logic       take
);
    logic c, l, f, z, n;
    logic unused_flags;
    assign c = psr[PSR_C];
    assign l = psr[PSR_L];
    assign f = psr[PSR_F];
    assign z = psr[PSR_Z];
    assign n = psr[PSR_N];
    assign unused_flags = ^{psr[1], psr[4:3]};

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take = z;
            COND_NE: take = !z;
            COND_CS: take = c;
            COND_CC: take = !c;
            COND_HI: take = l;
            COND_LS: take = !l;
            COND_GT: take = n;
            COND_LE: take = !n;
            COND_FS: take = f;
            COND_FC: take = !f;
            COND_LO: take = !l && !z;
            COND_HS: take = l || z;
            COND_LT: take = !n && !z;
            COND_GE: take = n || z;
            COND_UC: take = 1'b1;
            default: take = 1'b0;
        endcase
    end
endmodule

// File: rtl/controller_fsm.sv
// controller_fsm: multi-cycle CR16 control unit; Moore outputs from state and ir,
// except the load write-back strobe which waits for memReady.
module controller_fsm
    import cr16_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   memdata,
    input  logic [7:0]         PSROut,
    input  logic               memReady,
    output logic               PCEN,
    output logic               PSREN,
    output logic               nextInstruction,
    output logic               updateAddress,
    output logic               StoreReg,
    output logic               WriteData,
    output logic               regWrite,
    output logic               ZeroExtend,
    output logic               PCinstruction,
    output logic               SrcB,
    output logic               shiftType,
    output logic               resultEn,
    output logic               jumpEN,
    output logic               BranchEN,
    output logic               jalEN,
    output logic               memWrite,
    output logic [WIDTH-1:0]   shiftDir,
    output logic [7:0]         shiftAmt,
    output logic [REGBITS-1:0] ALUcond,
    output logic [1:0]         chooseResult
);
    state_t state, next, dnext;
    logic [WIDTH-1:0] ir;
    logic [3:0] op, ext, dop, dext, code;
    logic rtype, take, lshi;
    logic unused_ir;

    assign op    = ir[15:12];
    assign ext   = ir[7:4];
    assign dop   = memdata[15:12];
    assign dext  = memdata[7:4];
    assign rtype = op == OP_RTYPE;
    assign code  = rtype ? ext : op;
    assign lshi  = ext[3:1] == 3'b000;
    assign unused_ir = ^ir[11:8];

    // condition is judged on the incoming word, so it uses the live PSR
    cond_eval u_cond (.cond(memdata[11:8]), .psr(PSROut), .take(take));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= next;
            if (state == S_DECODE) ir <= memdata;
        end
    end

    always_comb begin
        dnext = S_PCINC;
        if ((dop == OP_RTYPE && is_alu_code(dext)) || is_alu_code(dop)) dnext = S_ALU;
        else if (dop == OP_SHIFT) dnext = S_SHIFT;
        else if (dop == OP_BCOND) dnext = take ? S_BRANCH : S_PCINC;
        else if (dop == OP_MEM)
            dnext = dext == EXT_LOAD ? S_LOAD_ADDR :
                    dext == EXT_STOR ? S_STORE :
                    dext == EXT_JAL  ? S_JAL :
                    (dext == EXT_JCOND && take) ? S_JUMP : S_PCINC;
    end

    always_comb begin
        next = S_FETCH;
        case (state)
            S_FETCH:     next = memReady ? S_DECODE : S_FETCH;
            S_DECODE:    next = dnext;
            S_ALU:       next = S_PCINC;
            S_SHIFT:     next = S_PCINC;
            S_LOAD_ADDR: next = S_LOAD_WB;
            S_LOAD_WB:   next = memReady ? S_PCINC : S_LOAD_WB;
            S_STORE:     next = memReady ? S_PCINC : S_STORE;
            default:     next = S_FETCH;
        endcase
    end

    always_comb begin
        PCEN = 1'b0; PSREN = 1'b0; nextInstruction = 1'b0; updateAddress = 1'b0;
        StoreReg = 1'b0; WriteData = 1'b0; regWrite = 1'b0; ZeroExtend = 1'b0;
        PCinstruction = 1'b0; SrcB = 1'b0; shiftType = 1'b0; resultEn = 1'b0;
        jumpEN = 1'b0; BranchEN = 1'b0; jalEN = 1'b0; memWrite = 1'b0;
        shiftDir = '0; shiftAmt = '0; ALUcond = '0; chooseResult = CR_SHIFT;
        case (state)
            S_DECODE: nextInstruction = 1'b1;
            S_ALU: begin
                resultEn     = 1'b1;
                chooseResult = CR_ALU;
                ALUcond      = REGBITS'(code);
                SrcB         = rtype;
                ZeroExtend   = !rtype && op inside {OP_ANDI, OP_ORI, OP_XORI, OP_MOVI};
                regWrite     = code != EXT_CMP;
                PSREN        = code inside {EXT_ADD, EXT_SUB, EXT_CMP};
            end
            S_SHIFT: begin
                regWrite  = 1'b1;
                shiftType = ext == EXT_LSH;
                shiftAmt  = lshi ? {4'b0, ir[3:0]} : 8'd0;
                shiftDir  = {WIDTH{lshi && ext[0]}};
            end
            S_LOAD_ADDR: updateAddress = 1'b1;
            S_LOAD_WB: begin
                updateAddress = 1'b1;
                regWrite      = memReady;
            end
            S_STORE: begin
                updateAddress = 1'b1;
                StoreReg      = 1'b1;
                memWrite      = 1'b1;
            end
            S_BRANCH: begin
                PCEN     = 1'b1;
                BranchEN = 1'b1;
            end
            S_JUMP: begin
                PCEN   = 1'b1;
                jumpEN = 1'b1;
            end
            S_JAL: begin
                PCEN         = 1'b1;
                jalEN        = 1'b1;
                regWrite     = 1'b1;
                chooseResult = CR_LINK;
            end
            S_PCINC: begin
                PCEN          = 1'b1;
                PCinstruction = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_controller_fsm.sv
// tb_controller_fsm: directed and random instructions checked cycle by cycle
// against an instruction-level expected trace.
module tb_controller_fsm;
    typedef struct packed {
        logic pcen, psren, nexti, upd, storereg, writedata, regwrite, zext;
        logic pcinstr, srcb, shtype, resen, jumpen, branchen, jalen, memwrite;
        logic [15:0] sdir;
        logic [7:0]  samt;
        logic [3:0]  alucond;
        logic [1:0]  cres;
    } ctl_t;

    logic clk = 1'b0, reset = 1'b0, memReady = 1'b0;
    logic [15:0] memdata = '0;
    logic [7:0]  PSROut = '0;
    logic PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData, regWrite, ZeroExtend;
    logic PCinstruction, SrcB, shiftType, resultEn, jumpEN, BranchEN, jalEN, memWrite;
    logic [15:0] shiftDir;
    logic [7:0]  shiftAmt;
    logic [3:0]  ALUcond;
    logic [1:0]  chooseResult;
    ctl_t obs;
    int errors = 0, checks = 0;

    controller_fsm dut (
        .clk(clk), .reset(reset), .memdata(memdata), .PSROut(PSROut), .memReady(memReady),
        .PCEN(PCEN), .PSREN(PSREN), .nextInstruction(nextInstruction), .updateAddress(updateAddress),
        .StoreReg(StoreReg), .WriteData(WriteData), .regWrite(regWrite), .ZeroExtend(ZeroExtend),
        .PCinstruction(PCinstruction), .SrcB(SrcB), .shiftType(shiftType), .resultEn(resultEn),
        .jumpEN(jumpEN), .BranchEN(BranchEN), .jalEN(jalEN), .memWrite(memWrite),
        .shiftDir(shiftDir), .shiftAmt(shiftAmt), .ALUcond(ALUcond), .chooseResult(chooseResult)
    );

    assign obs = {PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData, regWrite, ZeroExtend,
                  PCinstruction, SrcB, shiftType, resultEn, jumpEN, BranchEN, jalEN, memWrite,
                  shiftDir, shiftAmt, ALUcond, chooseResult};

    always #5 clk = ~clk;

    task automatic check(input ctl_t exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called at posedge+1: drive memReady, check, advance one cycle
    task automatic step(input ctl_t exp, input logic mr, input string tag);
        memReady = mr;
        #1;
        check(exp, tag);
        @(posedge clk);
        #1;
    endtask

    function automatic logic cond_true(input logic [3:0] c, input logic [7:0] p);
        logic fc, fl, ff, fz, fn;
        logic [15:0] t;
        fc = p[0]; fl = p[2]; ff = p[5]; fz = p[6]; fn = p[7];
        t = {1'b0, 1'b1, fn | fz, !fn & !fz, fl | fz, !fl & !fz, !ff, ff,
             !fn, fn, !fl, fl, !fc, fc, !fz, fz};
        return t[c];
    endfunction

    function automatic logic alu_code(input logic [3:0] c);
        return c == 1 || c == 2 || c == 3 || c == 5 || c == 9 || c == 11 || c == 13;
    endfunction

    task automatic pcinc_step();
        ctl_t e;
        e = '0; e.pcen = 1'b1; e.pcinstr = 1'b1;
        memdata = 16'($urandom); PSROut = 8'($urandom);
        step(e, 1'($urandom), "pcinc");
    endtask

    // full expected trace of one instruction, starting and ending in FETCH
    task automatic run_instr(input logic [15:0] ins, input logic [7:0] psr, input int fstall, input int mstall);
        ctl_t e;
        logic [3:0] op, rd, ext, imm, code;
        logic rt, tk;
        op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4]; imm = ins[3:0];
        rt = op == 4'd0 && alu_code(ext);
        tk = cond_true(rd, psr);
        memdata = ins; PSROut = 8'($urandom);
        for (int i = 0; i < fstall; i++) step('0, 1'b0, "fetch_hold");
        step('0, 1'b1, "fetch");
        PSROut = psr;
        e = '0; e.nexti = 1'b1;
        step(e, 1'($urandom), "decode");
        memdata = 16'($urandom); PSROut = 8'($urandom);
        e = '0;
        if (rt || alu_code(op)) begin
            code = rt ? ext : op;
            e.resen = 1'b1; e.cres = 2'b01; e.alucond = code; e.srcb = rt;
            e.zext = !rt && (op == 1 || op == 2 || op == 3 || op == 13);
            e.regwrite = code != 4'd11;
            e.psren = code == 5 || code == 9 || code == 11;
            step(e, 1'($urandom), "alu");
            pcinc_step();
        end else if (op == 4'd8) begin
            e.regwrite = 1'b1;
            if (ext == 4'd4) e.shtype = 1'b1;
            else begin
                e.samt = {4'd0, imm};
                e.sdir = ext[0] ? 16'hFFFF : 16'h0000;
            end
            step(e, 1'($urandom), "shift");
            pcinc_step();
        end else if (op == 4'd4 && ext == 4'd0) begin
            e.upd = 1'b1;
            step(e, 1'($urandom), "load_addr");
            for (int i = 0; i < mstall; i++) step(e, 1'b0, "load_hold");
            e.regwrite = 1'b1;
            step(e, 1'b1, "load_wb");
            pcinc_step();
        end else if (op == 4'd4 && ext == 4'd4) begin
            e.upd = 1'b1; e.storereg = 1'b1; e.memwrite = 1'b1;
            for (int i = 0; i < mstall; i++) step(e, 1'b0, "store_hold");
            step(e, 1'b1, "store");
            pcinc_step();
        end else if (op == 4'd4 && ext == 4'd8) begin
            e.pcen = 1'b1; e.jalen = 1'b1; e.regwrite = 1'b1; e.cres = 2'b11;
            step(e, 1'($urandom), "jal");
        end else if (op == 4'd12 && tk) begin
            e.pcen = 1'b1; e.branchen = 1'b1;
            step(e, 1'($urandom), "branch");
        end else if (op == 4'd4 && ext == 4'd12 && tk) begin
            e.pcen = 1'b1; e.jumpen = 1'b1;
            step(e, 1'($urandom), "jump");
        end else begin
            pcinc_step();
        end
    endtask

    initial begin
        ctl_t e;
        logic [15:0] ins;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            memdata = 16'($urandom); PSROut = 8'($urandom); memReady = 1'($urandom);
            @(posedge clk); #1;
            check('0, "reset_hold");
        end
        reset = 1'b1;
        step('0, 1'b0, "after_reset_fetch");

        run_instr(16'h0152, 8'($urandom), 0, 0);
        run_instr(16'hC012, 8'h40, 0, 0);
        run_instr(16'hC012, 8'h00, 0, 0);
        run_instr(16'h4340, 8'($urandom), 0, 2);
        run_instr(16'h4380, 8'($urandom), 0, 0);
        run_instr(16'h4105, 8'($urandom), 2, 1);
        run_instr(16'h4EC3, 8'h00, 1, 0);
        run_instr(16'hBD13, 8'($urandom), 0, 0);
        run_instr(16'h1D13, 8'($urandom), 0, 0);

        // reset in SHIFT must clear outputs at once and suppress PCEN
        memdata = 16'h8115;
        step('0, 1'b1, "lshi_fetch");
        e = '0; e.nexti = 1'b1;
        step(e, 1'b1, "lshi_decode");
        memdata = 16'($urandom);
        e = '0; e.regwrite = 1'b1; e.samt = 8'd5; e.sdir = 16'hFFFF;
        memReady = 1'b1; #1;
        check(e, "lshi_shift");
        reset = 1'b0; #1;
        check('0, "reset_async");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check('0, "reset_no_pcen");
        end
        reset = 1'b1;
        step('0, 1'b0, "post_abort_fetch");
        run_instr(16'h8044, 8'($urandom), 0, 0);

        for (int n = 0; n < 250; n++) begin
            ins = 16'($urandom);
            case ($urandom % 4)
                0: begin ins[15:12] = 4'd4; ins[7:4] = {2'($urandom), 2'b00}; end
                1: ins[15:12] = 4'd12;
                default: ;
            endcase
            if (ins[15:12] == 4'd8) ins[7:4] = ($urandom % 3 == 0) ? 4'd4 : 4'($urandom % 2);
            run_instr(ins, 8'($urandom), $urandom % 3, $urandom % 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
